// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and address decoder for the shared memory bus.
// Registers the owner's strobes/address/data onto the bus and returns read data.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 256,
    parameter int MAX_HOLD = 32
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Req0,
    input  logic              Req1,
    output logic              Gnt0,
    output logic              Gnt1,
    input  logic              nRead0,
    input  logic              nWrite0,
    input  logic              nRead1,
    input  logic              nWrite1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WrData0,
    input  logic [DATA_W-1:0] WrData1,
    output logic              nRead,
    output logic              nWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ExeDataOut,
    output logic              CsInstr,
    output logic              CsMatrix,
    output logic              CsMem,
    input  logic [DATA_W-1:0] InstructDataOut,
    input  logic [DATA_W-1:0] MatrixDataOut,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic [DATA_W-1:0] RdData,
    output logic              DecodeErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Wide enough that the saturated count always reaches MAX_HOLD-1.
    localparam int HOLD_W = $clog2(MAX_HOLD + 2);
    localparam logic [HOLD_W-1:0] HOLD_LIM =
        HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit PREEMPT_EN = (MAX_HOLD != 0);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                nread_q, nread_d;
    logic                nwrite_q, nwrite_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cs_instr_q, cs_instr_d;
    logic                cs_matrix_q, cs_matrix_d;
    logic                cs_mem_q, cs_mem_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_q, rd_d;

    logic                hold_done;
    logic                preempt0;
    logic                preempt1;
    logic                active;
    logic [3:0]          region;

    // Preemption only at a quiet point: other master waiting, holder idle.
    always_comb begin
        hold_done = PREEMPT_EN && (hold_q >= HOLD_LIM);
        preempt0  = hold_done && Req1 && nRead0 && nWrite0;
        preempt1  = hold_done && Req0 && nRead1 && nWrite1;
    end

    // Next-state: round-robin grant from IDLE, release or preempt back to IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (Req0 && (!Req1 || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                    hold_d  = '0;
                end else if (Req1) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT0: begin
                if (!Req0 || preempt0) begin
                    state_d = IDLE;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GRANT1: begin
                if (!Req1 || preempt1) begin
                    state_d = IDLE;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt0_d = (state_d == GRANT0);
        gnt1_d = (state_d == GRANT1);
    end

    // Bus mux: owner's signals while it keeps the grant, idle values otherwise.
    always_comb begin
        nread_d  = 1'b1;
        nwrite_d = 1'b1;
        addr_d   = '0;
        data_d   = '0;
        if (state_q == GRANT0 && state_d == GRANT0) begin
            nread_d  = nRead0 | ~nWrite0;
            nwrite_d = nWrite0;
            addr_d   = Addr0;
            data_d   = WrData0;
        end else if (state_q == GRANT1 && state_d == GRANT1) begin
            nread_d  = nRead1 | ~nWrite1;
            nwrite_d = nWrite1;
            addr_d   = Addr1;
            data_d   = WrData1;
        end
        active      = ~nread_d | ~nwrite_d;
        region      = addr_d[ADDR_W-1 -: 4];
        cs_instr_d  = active && (region == 4'h8);
        cs_matrix_d = active && (region == 4'h2);
        cs_mem_d    = active && (region == 4'h0);
        err_d       = active && !(cs_instr_d || cs_matrix_d || cs_mem_d);
    end

    // Read return: capture the selected target while a mapped read is on the bus.
    always_comb begin
        rd_d = rd_q;
        if (!nread_q) begin
            unique case (1'b1)
                cs_instr_q:  rd_d = InstructDataOut;
                cs_matrix_q: rd_d = MatrixDataOut;
                cs_mem_q:    rd_d = MemDataOut;
                default:     rd_d = rd_q;
            endcase
        end
    end

    // State, grant and bus registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            hold_q      <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            nread_q     <= 1'b1;
            nwrite_q    <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            cs_instr_q  <= 1'b0;
            cs_matrix_q <= 1'b0;
            cs_mem_q    <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            nread_q     <= nread_d;
            nwrite_q    <= nwrite_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cs_instr_q  <= cs_instr_d;
            cs_matrix_q <= cs_matrix_d;
            cs_mem_q    <= cs_mem_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
        end
    end

    assign Gnt0       = gnt0_q;
    assign Gnt1       = gnt1_q;
    assign nRead      = nread_q;
    assign nWrite     = nwrite_q;
    assign address    = addr_q;
    assign ExeDataOut = data_q;
    assign CsInstr    = cs_instr_q;
    assign CsMatrix   = cs_matrix_q;
    assign CsMem      = cs_mem_q;
    assign DecodeErr  = err_q;
    assign RdData     = rd_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps followed by random traffic
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int MAXH = 4;

    logic         Clk;
    logic         nReset;
    logic         Req0, Req1;
    logic         Gnt0, Gnt1;
    logic         nRead0, nWrite0, nRead1, nWrite1;
    logic [15:0]  Addr0, Addr1;
    logic [255:0] WrData0, WrData1;
    logic         nRead, nWrite;
    logic [15:0]  address;
    logic [255:0] ExeDataOut;
    logic         CsInstr, CsMatrix, CsMem;
    logic [255:0] InstructDataOut, MatrixDataOut, MemDataOut;
    logic [255:0] RdData;
    logic         DecodeErr;
    logic [2:0]   cs;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           own;
    int           lst;
    int           hld;
    logic         e_nr, e_nw, e_err;
    logic [15:0]  e_addr;
    logic [255:0] e_data, e_rd;
    logic [2:0]   e_cs;

    assign cs = {CsInstr, CsMatrix, CsMem};

    mem_bus_arbiter #(
        .ADDR_W(16),
        .DATA_W(256),
        .MAX_HOLD(MAXH)
    ) dut (
        .Clk(Clk),
        .nReset(nReset),
        .Req0(Req0),
        .Req1(Req1),
        .Gnt0(Gnt0),
        .Gnt1(Gnt1),
        .nRead0(nRead0),
        .nWrite0(nWrite0),
        .nRead1(nRead1),
        .nWrite1(nWrite1),
        .Addr0(Addr0),
        .Addr1(Addr1),
        .WrData0(WrData0),
        .WrData1(WrData1),
        .nRead(nRead),
        .nWrite(nWrite),
        .address(address),
        .ExeDataOut(ExeDataOut),
        .CsInstr(CsInstr),
        .CsMatrix(CsMatrix),
        .CsMem(CsMem),
        .InstructDataOut(InstructDataOut),
        .MatrixDataOut(MatrixDataOut),
        .MemDataOut(MemDataOut),
        .RdData(RdData),
        .DecodeErr(DecodeErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock of the bus as the rules describe it: who owns the bus,
    // what the targets see, and what comes back.
    task automatic model_step();
        int   nxt;
        logic sr, sw, my_req, oth_req, keep;
        logic [15:0]  a;
        logic [255:0] d;
        if (!nReset) begin
            own = -1; lst = 1; hld = 0;
            e_nr = 1'b1; e_nw = 1'b1; e_addr = '0; e_data = '0;
            e_cs = 3'b000; e_err = 1'b0; e_rd = '0;
            return;
        end
        if (!e_nr) begin
            if (e_cs[2]) e_rd = InstructDataOut;
            else if (e_cs[1]) e_rd = MatrixDataOut;
            else if (e_cs[0]) e_rd = MemDataOut;
        end
        sr = 1'b1; sw = 1'b1; a = '0; d = '0;
        nxt = own;
        if (own < 0) begin
            if (Req0 && Req1) nxt = 1 - lst;
            else if (Req0) nxt = 0;
            else if (Req1) nxt = 1;
            if (nxt >= 0) begin
                lst = nxt;
                hld = 0;
            end
        end else begin
            my_req  = (own == 0) ? Req0 : Req1;
            oth_req = (own == 0) ? Req1 : Req0;
            sr      = (own == 0) ? nRead0 : nRead1;
            sw      = (own == 0) ? nWrite0 : nWrite1;
            keep = my_req && !(MAXH != 0 && oth_req && hld >= MAXH - 1
                               && sr && sw);
            if (keep) begin
                if (hld < 1000) hld++;
                a = (own == 0) ? Addr0 : Addr1;
                d = (own == 0) ? WrData0 : WrData1;
            end else begin
                nxt = -1;
                sr = 1'b1; sw = 1'b1;
            end
        end
        own    = nxt;
        e_nw   = sw;
        e_nr   = sw ? sr : 1'b1;
        e_addr = a;
        e_data = d;
        e_cs   = 3'b000;
        e_err  = 1'b0;
        if (!e_nr || !e_nw) begin
            if (a[15:12] == 4'h8) e_cs = 3'b100;
            else if (a[15:12] == 4'h2) e_cs = 3'b010;
            else if (a[15:12] == 4'h0) e_cs = 3'b001;
            else e_err = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [3:0] nib;
        case ($urandom_range(0, 3))
            0: nib = 4'h0;
            1: nib = 4'h2;
            2: nib = 4'h8;
            default: nib = 4'($urandom_range(0, 15));
        endcase
        return {nib, 12'($urandom)};
    endfunction

    initial begin
        nReset = 1'b0; Req0 = 1'b1; Req1 = 1'b1;
        nRead0 = 1'b1; nWrite0 = 1'b1; nRead1 = 1'b1; nWrite1 = 1'b1;
        Addr0 = '0; Addr1 = '0; WrData0 = '0; WrData1 = '0;
        InstructDataOut = '0; MatrixDataOut = '0; MemDataOut = '0;

        // reset with both requests pending
        tick();
        tick();
        check("rst_gnt0", Gnt0, 0);
        check("rst_gnt1", Gnt1, 0);
        check("rst_nread", nRead, 1);
        check("rst_nwrite", nWrite, 1);
        check("rst_addr", address, 0);
        check("rst_data", ExeDataOut, 0);
        check("rst_cs", cs, 0);
        check("rst_rd", RdData, 0);
        check("rst_err", DecodeErr, 0);
        nReset = 1'b1;
        tick();
        check("tie_gnt0", Gnt0, 1);
        check("tie_gnt1", Gnt1, 0);

        // single-master read from main memory
        Req1 = 1'b0; nRead0 = 1'b0; Addr0 = 16'h0004;
        MemDataOut = 256'hA5;
        tick();
        check("rd_nread", nRead, 0);
        check("rd_addr", address, 16'h0004);
        check("rd_cs", cs, 3'b001);
        nRead0 = 1'b1;
        tick();
        check("rd_data", RdData, 256'hA5);
        check("rd_idle", nRead, 1);

        // round-robin: M0 busy reading while M1 waits
        Req1 = 1'b1; nRead0 = 1'b0; Addr0 = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_hold0", Gnt0, 1);
            check("rr_wait1", Gnt1, 0);
        end
        Req0 = 1'b0; nRead0 = 1'b1;
        tick();
        check("rr_rel_gnt0", Gnt0, 0);
        check("rr_rel_gnt1", Gnt1, 0);
        check("rr_rel_nread", nRead, 1);
        check("rr_rel_nwrite", nWrite, 1);
        Req0 = 1'b1;
        tick();
        check("rr_gnt1", Gnt1, 1);
        check("rr_gnt0", Gnt0, 0);

        // M1 writes the matrix unit, then reads instr and unmapped space
        nWrite1 = 1'b0; Addr1 = 16'h2011; WrData1 = 256'h3;
        tick();
        check("mx_cs", cs, 3'b010);
        check("mx_nwrite", nWrite, 0);
        check("mx_nread", nRead, 1);
        check("mx_data", ExeDataOut, 256'h3);
        check("mx_addr", address, 16'h2011);
        check("mx_gnt0", Gnt0, 0);
        nWrite1 = 1'b1; nRead1 = 1'b0; Addr1 = 16'h8000;
        InstructDataOut = 256'h1234_5678;
        tick();
        check("ir_cs", cs, 3'b100);
        check("ir_nread", nRead, 0);
        Addr1 = 16'h5000;
        tick();
        check("ir_rd", RdData, 256'h1234_5678);
        check("ue_err", DecodeErr, 1);
        check("ue_cs", cs, 0);
        nRead1 = 1'b1; Req1 = 1'b0;
        tick();
        check("ue_pulse", DecodeErr, 0);
        check("ue_rd", RdData, 256'h1234_5678);
        check("m1_rel_gnt1", Gnt1, 0);
        check("m1_rel_gnt0", Gnt0, 0);
        tick();
        check("m0_after_rel", Gnt0, 1);

        // preemption of M0 with idle strobes
        Req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_hold0", Gnt0, 1);
        end
        tick();
        check("pre_drop0", Gnt0, 0);
        check("pre_drop1", Gnt1, 0);
        tick();
        check("pre_gnt1", Gnt1, 1);

        // M1 preempted in turn, M0 back
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_hold1", Gnt1, 1);
        end
        tick();
        check("pre_drop_m1", Gnt1, 0);
        tick();
        check("pre_back0", Gnt0, 1);

        // no preemption while M0 keeps a read strobe low
        nRead0 = 1'b0; Addr0 = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("prb_hold0", Gnt0, 1);
        end
        nRead0 = 1'b1;
        tick();
        check("prb_drop0", Gnt0, 0);
        tick();
        check("prb_gnt1", Gnt1, 1);

        // reset during an M1 write
        nWrite1 = 1'b0; Addr1 = 16'h0100; WrData1 = 256'h9;
        tick();
        check("mt_nwrite", nWrite, 0);
        check("mt_cs", cs, 3'b001);
        nReset = 1'b0;
        tick();
        check("mt_rst_nwrite", nWrite, 1);
        check("mt_rst_gnt1", Gnt1, 0);
        check("mt_rst_cs", cs, 0);
        nReset = 1'b1; nWrite1 = 1'b1;
        tick();
        check("mt_tie_gnt0", Gnt0, 1);

        // both strobes low: write wins
        nRead0 = 1'b0; nWrite0 = 1'b0; Addr0 = 16'h0020;
        WrData0 = 256'h77;
        tick();
        check("sc_nread", nRead, 1);
        check("sc_nwrite", nWrite, 0);
        check("sc_data", ExeDataOut, 256'h77);
        check("sc_cs", cs, 3'b001);
        nRead0 = 1'b1; nWrite0 = 1'b1;
        tick();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            nReset  = ($urandom_range(0, 149) != 0);
            Req0    = ($urandom_range(0, 7) != 0);
            Req1    = ($urandom_range(0, 7) != 0);
            nRead0  = ($urandom_range(0, 2) != 0);
            nWrite0 = ($urandom_range(0, 2) != 0);
            nRead1  = ($urandom_range(0, 2) != 0);
            nWrite1 = ($urandom_range(0, 2) != 0);
            Addr0   = rand_addr();
            Addr1   = rand_addr();
            WrData0 = rand256();
            WrData1 = rand256();
            InstructDataOut = rand256();
            MatrixDataOut   = rand256();
            MemDataOut      = rand256();
            tick();
            check("rnd_gnt0", Gnt0, (own == 0));
            check("rnd_gnt1", Gnt1, (own == 1));
            check("rnd_nread", nRead, e_nr);
            check("rnd_nwrite", nWrite, e_nw);
            check("rnd_addr", address, e_addr);
            check("rnd_data", ExeDataOut, e_data);
            check("rnd_cs", cs, e_cs);
            check("rnd_err", DecodeErr, e_err);
            check("rnd_rd", RdData, e_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter and address decoder for the shared 256-bit memory bus. Master 0 is the execution engine; master 1 is the program/matrix loader (DMA). It grants the bus round-robin with a per-grant hold limit, registers the granted master's strobes/address/data onto the bus, and decodes the address into chip selects for instruction memory (0x8xxx), matrix ALU (0x2xxx) and main memory (0x0xxx). It returns read data from the selected target.

Parameters:
ADDR_W, 16, bus address width; decode uses address[ADDR_W-1:ADDR_W-4]
DATA_W, 256, bus data width
MAX_HOLD, 32, maximum cycles a master may hold the grant while the other requests; 0 disables preemption

Ports:
Clk  in  1  clock, all logic on posedge
nReset  in  1  synchronous active-low reset, sampled on posedge Clk
Req0, Req1  in  1 each  bus request, master 0 / master 1
Gnt0, Gnt1  out  1 each  bus grant, registered, one-hot or both 0
nRead0, nWrite0, nRead1, nWrite1  in  1 each  active-low strobes per master
Addr0, Addr1  in  ADDR_W each  master addresses
WrData0, WrData1  in  DATA_W each  master write data
nRead, nWrite  out  1 each  bus strobes to targets
address  out  ADDR_W  bus address
ExeDataOut  out  DATA_W  bus write data
CsInstr, CsMatrix, CsMem  out  1 each  target selects, one-hot or all 0
InstructDataOut, MatrixDataOut, MemDataOut  in  DATA_W each  target read data
RdData  out  DATA_W  returned read data, shared by both masters
DecodeErr  out  1  one-cycle pulse, active strobe to an unmapped region

Behaviour:
- Reset (nReset==0 at posedge Clk) applies regardless of state, including mid-transfer. State goes to IDLE.
  - Outputs: Gnt0=Gnt1=0, nRead=nWrite=1, address=0, ExeDataOut=0, all Cs*=0, RdData=0, DecodeErr=0.
  - Internal: lastGnt=1, so master 0 wins the first tie; holdCnt=0.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - If both Req are high, grant the master != lastGnt.
  - If only one Req is high, grant it.
  - The Gnt bit rises the next cycle. Set lastGnt to the granted master and clear holdCnt.
  - Bus outputs sit at idle values: strobes 1, address 0, data 0.
- GRANTx:
  - Each cycle, register nReadx/nWritex/Addrx/WrDatax onto the bus. Bus lags the master by 1 cycle.
  - The non-granted master's signals are ignored.
  - holdCnt increments each cycle and saturates.
- Release: Reqx low while in GRANTx moves to IDLE. Gntx drops next cycle, and the bus returns to idle values that cycle. This guarantees at least one turnaround cycle between owners.
- Preemption: applies when MAX_HOLD!=0, the other Req is high, holdCnt>=MAX_HOLD-1, and nReadx==nWritex==1 (no transfer in flight).
  - The arbiter moves to IDLE and drops Gntx.
  - It never preempts while a strobe is low, so the holder may overrun MAX_HOLD until its strobes are idle.
  - The holder must see Gnt low and stop driving.
- Simultaneous Req release and other-master Req: still passes through IDLE, so the other master's Gnt rises 2 cycles after release.
- Strobe conflict: if both strobes of the granted master are low, write wins and the bus shows nRead=1, nWrite=0.
- Decode: registered alongside the bus, asserted only while nRead==0 or nWrite==0.
  - address[15:12]==4'h8 gives CsInstr.
  - address[15:12]==4'h2 gives CsMatrix.
  - address[15:12]==4'h0 gives CsMem.
  - Any other value gives no select, and DecodeErr pulses one cycle for that cycle's strobe.
- Read return: each cycle the bus nRead==0 and a Cs is active, RdData <= data from the selected target input. Otherwise RdData holds.
  - Master-visible read latency is 2 cycles from the master driving nRead low: 1 cycle bus register plus 1 cycle return register.
  - Unmapped reads leave RdData unchanged.
- Writes: the target captures ExeDataOut while nWrite==0 and its Cs is high. The arbiter has no write acknowledge.

Test Plan:
- Reset then idle: nReset=0 for 2 cycles with Req0=Req1=1 -> Gnt0=Gnt1=0, nRead=nWrite=1, address=0; first cycle after release -> Gnt0=1 (lastGnt=1 tie-break).
- Single-master read: Req0=1, after Gnt0 drive nRead0=0, Addr0=16'h0004, MemDataOut=256'hA5 -> next cycle nRead=0, address=16'h0004, CsMem=1; following cycle RdData=256'hA5.
- Round-robin: Req0, Req1 both held; M0 drops Req0 after 5 cycles -> Gnt0 low, one idle cycle (strobes 1), then Gnt1=1; Req0 reasserted -> M0 is granted only after M1 releases.
- Preemption: MAX_HOLD=4, Req0 held with strobes idle, Req1=1 -> Gnt0 drops after the 4th held cycle and Gnt1 rises next cycle. Repeat with nRead0 held low -> no preemption until nRead0=1.
- Decode/matrix path: write Addr1=16'h2011, WrData1=256'h3 -> CsMatrix=1, nWrite=0, ExeDataOut=3. Read Addr1=16'h8000 -> CsInstr=1, RdData=InstructDataOut. Read Addr1=16'h5000 -> DecodeErr single-cycle pulse, RdData unchanged.
- Reset mid-transfer: assert nReset=0 while nWrite=0 under Gnt1 -> next edge nWrite=1, Gnt1=0, CsMem=0; after release the first tie goes to master 0.
